// File: rtl/pipe_stage_chain.sv
// Transition-register chain from decode (stage 0 = EX input) to writeback (last stage).
// Handles memory hold, branch flush, RAW hazard bubbles and saturating perf counters.
module pipe_stage_chain #(
    parameter int WIDTH       = 16,
    parameter int STAGES      = 4,
    parameter int MEM_STAGE   = 2,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [2:0]              in_dest,
    input  logic                    in_wr,
    input  logic [2:0]              in_src_a,
    input  logic [2:0]              in_src_b,
    input  logic                    in_use_a,
    input  logic                    in_use_b,
    input  logic                    hold_req,
    input  logic                    flush,
    output logic                    in_ready,
    output logic                    hazard,
    output logic [STAGES-1:0]       stage_valid,
    output logic [STAGES*WIDTH-1:0] stage_data,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [2:0]              out_dest,
    output logic                    out_wr,
    output logic [15:0]             stall_cnt,
    output logic [15:0]             bubble_cnt
);

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] wr;
    logic [WIDTH-1:0]  data [STAGES];
    logic [2:0]        dest [STAGES];

    logic [STAGES-1:0] vld_nxt;
    logic [STAGES-1:0] wr_nxt;
    logic [WIDTH-1:0]  data_nxt [STAGES];
    logic [2:0]        dest_nxt [STAGES];

    logic [STAGES-1:0] kill;
    logic              match_a;
    logic              match_b;
    logic              load;
    logic              bubble_in;

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
        sat_inc = (en && (cnt != 16'hFFFF)) ? cnt + 16'd1 : cnt;
    endfunction

    // Hazard detect: any valid in-flight writer, including the retiring stage,
    // blocks a reader until the regfile has been written.
    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (vld[k] && wr[k] && (dest[k] == in_src_a)) match_a = 1'b1;
            if (vld[k] && wr[k] && (dest[k] == in_src_b)) match_b = 1'b1;
        end
    end

    assign hazard    = in_valid & ((in_use_a & match_a) | (in_use_b & match_b));
    assign load      = in_valid & ~hazard & ~flush;
    assign in_ready  = ~reset & load & ~hold_req;
    assign bubble_in = in_valid & ~hold_req & ~load;

    // Flush squashes the instructions sitting in the young stages, wherever they move next.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            kill[k] = flush && (k < FLUSH_DEPTH);
        end
    end

    always_comb begin
        vld_nxt[0]  = vld[0] & ~kill[0];
        wr_nxt[0]   = wr[0];
        data_nxt[0] = data[0];
        dest_nxt[0] = dest[0];
        if (!hold_req) begin
            vld_nxt[0]  = load;
            wr_nxt[0]   = in_wr;
            data_nxt[0] = in_data;
            dest_nxt[0] = in_dest;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (hold_req && (k <= MEM_STAGE)) begin
                vld_nxt[k]  = vld[k] & ~kill[k];
                wr_nxt[k]   = wr[k];
                data_nxt[k] = data[k];
                dest_nxt[k] = dest[k];
            end else begin
                vld_nxt[k]  = vld[k-1] & ~kill[k-1] & ~(hold_req && (k == MEM_STAGE + 1));
                wr_nxt[k]   = wr[k-1];
                data_nxt[k] = data[k-1];
                dest_nxt[k] = dest[k-1];
            end
        end
    end

    // Stage register boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld        <= '0;
            wr         <= '0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data[k] <= '0;
                dest[k] <= '0;
            end
        end else begin
            vld        <= vld_nxt;
            wr         <= wr_nxt;
            stall_cnt  <= sat_inc(stall_cnt, hold_req);
            bubble_cnt <= sat_inc(bubble_cnt, bubble_in);
            for (int k = 0; k < STAGES; k++) begin
                data[k] <= data_nxt[k];
                dest[k] <= dest_nxt[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_data[k*WIDTH +: WIDTH] = data[k];
        end
    end

    assign stage_valid = vld;
    assign out_valid   = vld[STAGES-1];
    assign out_data    = data[STAGES-1];
    assign out_dest    = dest[STAGES-1];
    assign out_wr      = wr[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain with a retire-order scoreboard.
module tb_pipe_stage_chain;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic [2:0]              in_dest;
    logic                    in_wr;
    logic [2:0]              in_src_a;
    logic [2:0]              in_src_b;
    logic                    in_use_a;
    logic                    in_use_b;
    logic                    hold_req;
    logic                    flush;
    logic                    in_ready;
    logic                    hazard;
    logic [STAGES-1:0]       stage_valid;
    logic [STAGES*WIDTH-1:0] stage_data;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [2:0]              out_dest;
    logic                    out_wr;
    logic [15:0]             stall_cnt;
    logic [15:0]             bubble_cnt;

    pipe_stage_chain #(
        .WIDTH(WIDTH), .STAGES(STAGES), .MEM_STAGE(2), .FLUSH_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest), .in_wr(in_wr),
        .in_src_a(in_src_a), .in_src_b(in_src_b), .in_use_a(in_use_a), .in_use_b(in_use_b),
        .hold_req(hold_req), .flush(flush),
        .in_ready(in_ready), .hazard(hazard),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest), .out_wr(out_wr),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [18:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_data = '0; in_dest = '0; in_wr = 1'b0;
        in_src_a = '0; in_src_b = '0; in_use_a = 1'b0; in_use_b = 1'b0;
        hold_req = 1'b0; flush = 1'b0;
    endtask

    task automatic present(input logic [15:0] d, input logic [2:0] r, input logic w);
        in_valid = 1'b1; in_data = d; in_dest = r; in_wr = w;
    endtask

    // Scoreboard: accepted instructions are queued, retiring ones must match in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) check("sb_unexpected_retire", 32'(sb.size()), 32'd1);
                else check("sb_retire", {13'd0, out_dest, out_data}, {13'd0, sb.pop_front()});
            end
            if (in_ready) sb.push_back({in_dest, in_data});
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        in_valid = 1'b1;
        #3;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_stage_valid", stage_valid, 4'b0000);
        in_valid = 1'b0;
        #9;
        reset = 1'b0;
        tick();

        // Straight-line: six independent instructions
        for (int c = 0; c < 12; c++) begin
            if (c < 6) present(16'(c + 1), 3'(c), 1'b1);
            else idle();
            #1;
            check("straight_out_valid", out_valid, (c >= 4 && c <= 9));
            tick();
        end
        check("straight_stall_cnt", stall_cnt, 16'd0);
        check("straight_bubble_cnt", bubble_cnt, 16'd0);

        // RAW: writer of R3 then reader of R3
        present(16'h00A0, 3'd3, 1'b1);
        #1;
        check("raw_writer_ready", in_ready, 1'b1);
        tick();
        for (int c = 1; c <= 4; c++) begin
            present(16'h00B0, 3'd4, 1'b1);
            if (c < 3) begin in_use_a = 1'b1; in_src_a = 3'd3; in_use_b = 1'b0; end
            else begin in_use_a = 1'b0; in_use_b = 1'b1; in_src_b = 3'd3; in_src_a = 3'd0; end
            #1;
            check("raw_hazard", hazard, 1'b1);
            check("raw_in_ready_blocked", in_ready, 1'b0);
            if (c == 4) begin
                check("raw_writer_out_valid", out_valid, 1'b1);
                check("raw_writer_out_data", out_data, 16'h00A0);
            end
            tick();
        end
        #1;
        check("raw_hazard_clear", hazard, 1'b0);
        check("raw_reader_ready", in_ready, 1'b1);
        tick();
        idle();
        for (int c = 6; c <= 10; c++) begin
            check("raw_reader_out_valid", out_valid, (c == 9));
            if (c == 9) check("raw_reader_out_data", out_data, 16'h00B0);
            tick();
        end
        check("raw_bubble_cnt", bubble_cnt, 16'd4);
        repeat (2) tick();

        // Memory stall: three hold cycles with stage 2 valid
        for (int c = 0; c < 3; c++) begin
            present(16'(16'h21 + c), 3'(5 + c), 1'b0);
            tick();
        end
        idle();
        check("stall_pre_valid", stage_valid, 4'b0111);
        hold_req = 1'b1;
        for (int c = 4; c <= 6; c++) begin
            tick();
            if (c == 6) hold_req = 1'b0;
            check("stall_frozen_valid", stage_valid, 4'b0111);
            check("stall_frozen_data2", stage_data[2*WIDTH +: WIDTH], 16'h0021);
            check("stall_out_bubble", out_valid, 1'b0);
        end
        tick();
        check("stall_resume_valid", stage_valid, 4'b1110);
        check("stall_resume_out", out_data, 16'h0021);
        check("stall_cnt", stall_cnt, 16'd3);
        repeat (4) tick();

        // Flush with all four stages valid
        for (int c = 0; c < 4; c++) begin
            present(16'(16'h31 + c), 3'd0, 1'b0);
            tick();
        end
        check("flush_pre_valid", stage_valid, 4'b1111);
        present(16'h0035, 3'd0, 1'b0);
        flush = 1'b1;
        void'(sb.pop_back());
        void'(sb.pop_back());
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        tick();
        idle();
        check("flush_valid", stage_valid, 4'b1000);
        check("flush_survivor", out_data, 16'h0032);
        check("flush_bubble_cnt", bubble_cnt, 16'd5);
        repeat (4) tick();

        // Flush during hold
        for (int c = 0; c < 3; c++) begin
            present(16'(16'h41 + c), 3'd0, 1'b0);
            tick();
        end
        idle();
        hold_req = 1'b1;
        flush = 1'b1;
        void'(sb.pop_back());
        void'(sb.pop_back());
        tick();
        idle();
        check("flush_hold_valid", stage_valid, 4'b0100);
        check("flush_hold_data2", stage_data[2*WIDTH +: WIDTH], 16'h0041);
        check("flush_hold_stall_cnt", stall_cnt, 16'd4);
        repeat (4) tick();

        // Asynchronous reset mid-stream
        for (int c = 0; c < 3; c++) begin
            present(16'(16'h51 + c), 3'(c), 1'b0);
            tick();
        end
        check("areset_pre_valid", stage_valid, 4'b0111);
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        check("areset_stage_valid", stage_valid, 4'b0000);
        check("areset_out_valid", out_valid, 1'b0);
        check("areset_stall_cnt", stall_cnt, 16'd0);
        check("areset_bubble_cnt", bubble_cnt, 16'd0);
        check("areset_in_ready", in_ready, 1'b0);
        idle();
        #1;
        reset = 1'b0;
        tick();
        present(16'h0061, 3'd1, 1'b1);
        tick();
        idle();
        repeat (6) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
